sb_io: RTL and testbench

Behavioural model of the iCE40 programmable I/O cell: one bidirectional package pin with optional input capture and output/enable registers. It sits between the top-level pad and fabric logic, for example pull-up button inputs feeding debounce logic. Pin mode is selected statically by `PIN_TYPE`; all cell registers share one clock and one reset.

---
 rtl/sb_io_pkg.sv | 24 ++
 rtl/sb_io_ff.sv | 48 ++++
 rtl/sb_io.sv | 118 +++++++++++
 tb/tb_sb_io.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_io_pkg.sv
// Shared definitions for the sb_io programmable I/O cell.
// PIN_TYPE[1:0] selects the input mode, PIN_TYPE[3:2] the output data
// source and PIN_TYPE[5:4] the pad driver enable source.
package sb_io_pkg;

   // Input mode, PIN_TYPE[1:0]
   localparam logic [1:0] IN_REG       = 2'b00;  // registered / DDR capture
   localparam logic [1:0] IN_DIRECT    = 2'b01;  // pad straight to fabric
   localparam logic [1:0] IN_REG_LATCH = 2'b10;  // registered, frozen by LATCH_INPUT_VALUE
   localparam logic [1:0] IN_LATCH     = 2'b11;  // transparent latch

   // Output data select, PIN_TYPE[3:2]
   localparam logic [1:0] OUT_DDR      = 2'b00;
   localparam logic [1:0] OUT_REG      = 2'b01;
   localparam logic [1:0] OUT_DIRECT   = 2'b10;
   localparam logic [1:0] OUT_REG_INV  = 2'b11;

   // Output enable source, PIN_TYPE[5:4]
   localparam logic [1:0] OE_NEVER     = 2'b00;
   localparam logic [1:0] OE_ALWAYS    = 2'b01;
   localparam logic [1:0] OE_DIRECT    = 2'b10;
   localparam logic [1:0] OE_REG       = 2'b11;

endpackage

// File: rtl/sb_io_ff.sv
// Single-bit cell register: clock enable, hold, asynchronous active-low clear.
// Ports:
//   clk   - cell clock (edge chosen by NEG_EDGE)
//   rst_n - asynchronous clear, active low
//   ce    - update enable
//   hold  - freezes the register even when ce=1
//   d     - data in
//   q     - registered data out
module sb_io_ff #(
   parameter bit NEG_EDGE = 1'b0   // 1 = capture on the falling edge
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic hold,
   input  logic d,
   output logic q
);

   logic q_d;
   logic q_q;

   always_comb begin
      q_d = q_q;
      if (ce && !hold) begin
         q_d = d;
      end
   end

   generate
      if (NEG_EDGE) begin : g_neg
         // NOTE: sequential state always uses non-blocking assignment so every
         // flop samples pre-edge values regardless of process ordering.
         always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) q_q <= 1'b0;
            else        q_q <= q_d;
         end
      end else begin : g_pos
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_q <= 1'b0;
            else        q_q <= q_d;
         end
      end
   endgenerate

   assign q = q_q;

endmodule

// File: rtl/sb_io.sv
// Behavioural iCE40-style programmable I/O cell: one bidirectional pad with
// optional input capture (SDR/DDR/latch) and output/enable registers.
// Ports:
//   clk               - cell clock, shared by all cell registers
//   rst_n             - asynchronous clear of all cell registers, active low
//   PACKAGE_PIN       - the pad (inout)
//   CLOCK_ENABLE      - register update enable (tie high when unused)
//   LATCH_INPUT_VALUE - freezes the input path in the latch modes
//   OUTPUT_ENABLE     - pad driver enable (tie low when unused)
//   D_OUT_0/D_OUT_1   - output data; D_OUT_1 is the opposite-edge DDR data
//   D_IN_0/D_IN_1     - input data; D_IN_1 is the opposite-edge DDR sample
module sb_io
   import sb_io_pkg::*;
#(
   parameter logic [5:0] PIN_TYPE    = 6'b000000,
   parameter bit         PULLUP      = 1'b0,
   parameter bit         NEG_TRIGGER = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   inout  wire  PACKAGE_PIN,
   input  logic CLOCK_ENABLE,
   input  logic LATCH_INPUT_VALUE,
   input  logic OUTPUT_ENABLE,
   input  logic D_OUT_0,
   input  logic D_OUT_1,
   output logic D_IN_0,
   output logic D_IN_1
);

   localparam logic [1:0] IN_MODE = PIN_TYPE[1:0];
   localparam logic [1:0] OUT_SEL = PIN_TYPE[3:2];
   localparam logic [1:0] OE_MODE = PIN_TYPE[5:4];

   logic pin_in;
   logic in_hold;
   logic in0_q, in1_q, out0_q, out1_q, oe_q;
   logic latch_q;
   logic active_phase;
   logic pad_data;
   logic pad_drive;

   assign pin_in  = PACKAGE_PIN;
   assign in_hold = (IN_MODE == IN_REG_LATCH) && LATCH_INPUT_VALUE;

   // Active-edge registers
   sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_in0 (
      .clk(clk), .rst_n(rst_n), .ce(CLOCK_ENABLE), .hold(in_hold),
      .d(pin_in), .q(in0_q));
   sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_out0 (
      .clk(clk), .rst_n(rst_n), .ce(CLOCK_ENABLE), .hold(1'b0),
      .d(D_OUT_0), .q(out0_q));
   sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_oe (
      .clk(clk), .rst_n(rst_n), .ce(CLOCK_ENABLE), .hold(1'b0),
      .d(OUTPUT_ENABLE), .q(oe_q));

   // Opposite-edge registers for the DDR halves
   sb_io_ff #(.NEG_EDGE(!NEG_TRIGGER)) u_in1 (
      .clk(clk), .rst_n(rst_n), .ce(CLOCK_ENABLE), .hold(in_hold),
      .d(pin_in), .q(in1_q));
   sb_io_ff #(.NEG_EDGE(!NEG_TRIGGER)) u_out1 (
      .clk(clk), .rst_n(rst_n), .ce(CLOCK_ENABLE), .hold(1'b0),
      .d(D_OUT_1), .q(out1_q));

   // NOTE: this is a deliberate level-sensitive latch; always_latch states the
   // intent, whereas an incomplete always_comb would infer one by accident.
   always_latch begin
      if (!rst_n) begin
         latch_q <= 1'b0;
      end else if (!LATCH_INPUT_VALUE) begin
         latch_q <= pin_in;
      end
   end

   always_comb begin
      D_IN_0 = in0_q;
      D_IN_1 = 1'b0;
      case (IN_MODE)
         IN_DIRECT:    D_IN_0 = pin_in;
         IN_LATCH:     D_IN_0 = LATCH_INPUT_VALUE ? latch_q : pin_in;
         default:      D_IN_1 = in1_q;   // IN_REG, IN_REG_LATCH
      endcase
   end

   // The active phase is the half-cycle that follows the active edge.
   assign active_phase = clk ^ NEG_TRIGGER;

   always_comb begin
      pad_data = 1'b0;
      case (OUT_SEL)
         OUT_DDR:     pad_data = active_phase ? out0_q : out1_q;
         OUT_REG:     pad_data = out0_q;
         OUT_DIRECT:  pad_data = D_OUT_0;
         OUT_REG_INV: pad_data = !out0_q;
         default:     pad_data = 1'b0;
      endcase
   end

   always_comb begin
      pad_drive = 1'b0;
      case (OE_MODE)
         OE_ALWAYS: pad_drive = 1'b1;
         OE_DIRECT: pad_drive = OUTPUT_ENABLE;
         OE_REG:    pad_drive = oe_q;
         default:   pad_drive = 1'b0;
      endcase
   end

   assign PACKAGE_PIN = pad_drive ? pad_data : 1'bz;

   // Weak pull-up: only resolves the pad when nobody drives it.
   generate
      if (PULLUP) begin : g_pullup
         pullup (PACKAGE_PIN);
      end
   endgenerate

endmodule

// File: tb/tb_sb_io.sv
module tb_sb_io;

   logic clk = 1'b0;
   logic rst_n, ce, liv, oe, d0, d1;
   logic a_ext_en, a_ext_val, c_ext, d_ext;

   wire pad_a, pad_b, pad_c, pad_d, pad_e, pad_f, pad_g;
   logic a_in0, a_in1, b_in0, b_in1, c_in0, c_in1, d_in0, d_in1;
   logic e_in0, e_in1, f_in0, f_in1, g_in0, g_in1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign pad_a = a_ext_en ? a_ext_val : 1'bz;
   assign pad_c = c_ext;
   assign pad_d = d_ext;

   // a: direct in/out, direct OE, pull-up
   sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_a), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(a_in0), .D_IN_1(a_in1));
   // b: registered output, always driven, registered input
   sb_io #(.PIN_TYPE(6'b010100)) u_b (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_b), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(b_in0), .D_IN_1(b_in1));
   // c: DDR input only
   sb_io #(.PIN_TYPE(6'b000000)) u_c (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_c), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(c_in0), .D_IN_1(c_in1));
   // d: input latch
   sb_io #(.PIN_TYPE(6'b000011)) u_d (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_d), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(d_in0), .D_IN_1(d_in1));
   // e: registered output with registered OE, pull-up makes high-Z read as 1
   sb_io #(.PIN_TYPE(6'b110100), .PULLUP(1'b1)) u_e (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_e), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(e_in0), .D_IN_1(e_in1));
   // f: DDR output, always driven
   sb_io #(.PIN_TYPE(6'b010000)) u_f (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_f), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(f_in0), .D_IN_1(f_in1));
   // g: registered inverted output, always driven, direct input
   sb_io #(.PIN_TYPE(6'b011101)) u_g (
      .clk(clk), .rst_n(rst_n), .PACKAGE_PIN(pad_g), .CLOCK_ENABLE(ce),
      .LATCH_INPUT_VALUE(liv), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
      .D_IN_0(g_in0), .D_IN_1(g_in1));

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic oe;
      logic d0;
      logic ext_en;
      logic ext_val;
      logic exp_pad;
      logic exp_din0;
   } vec_t;

   vec_t vecs[6];

   // Reference model: values captured at the most recent enabled edges.
   logic m_q0, m_q1, m_bin0, m_bin1, m_cin0, m_cin1;

   initial begin
      rst_n = 1'b0; ce = 1'b1; liv = 1'b0; oe = 1'b1; d0 = 1'b1; d1 = 1'b1;
      a_ext_en = 1'b0; a_ext_val = 1'b0; c_ext = 1'b1; d_ext = 1'b0;

      // Combinational pad behaviour of the direct cell with pull-up.
      vecs[0] = '{oe:1'b0, d0:1'b0, ext_en:1'b0, ext_val:1'b0, exp_pad:1'b1, exp_din0:1'b1};
      vecs[1] = '{oe:1'b0, d0:1'b1, ext_en:1'b1, ext_val:1'b0, exp_pad:1'b0, exp_din0:1'b0};
      vecs[2] = '{oe:1'b0, d0:1'b0, ext_en:1'b1, ext_val:1'b1, exp_pad:1'b1, exp_din0:1'b1};
      vecs[3] = '{oe:1'b1, d0:1'b0, ext_en:1'b0, ext_val:1'b0, exp_pad:1'b0, exp_din0:1'b0};
      vecs[4] = '{oe:1'b1, d0:1'b1, ext_en:1'b0, ext_val:1'b0, exp_pad:1'b1, exp_din0:1'b1};
      vecs[5] = '{oe:1'b0, d0:1'b1, ext_en:1'b0, ext_val:1'b1, exp_pad:1'b1, exp_din0:1'b1};

      // Reset state, before any clock edge.
      #2;
      check("rst_b_pad", pad_b, 1'b0);
      check("rst_b_in0", b_in0, 1'b0);
      check("rst_c_in0", c_in0, 1'b0);
      check("rst_c_in1", c_in1, 1'b0);
      check("rst_g_pad_inv", pad_g, 1'b1);
      check("rst_e_pad_released", pad_e, 1'b1);
      check("rst_f_pad_q1", pad_f, 1'b0);

      for (int i = 0; i < 6; i++) begin
         oe = vecs[i].oe; d0 = vecs[i].d0;
         a_ext_en = vecs[i].ext_en; a_ext_val = vecs[i].ext_val;
         #1;
         check($sformatf("vec%0d_pad", i), pad_a, vecs[i].exp_pad);
         check($sformatf("vec%0d_din0", i), a_in0, vecs[i].exp_din0);
         check($sformatf("vec%0d_din1", i), a_in1, 1'b0);
      end
      a_ext_en = 1'b0;
      // A rising edge has passed with CE=1 while in reset: reset must win.
      check("rst_wins_b_pad", pad_b, 1'b0);
      check("rst_wins_e_pad", pad_e, 1'b1);

      // Registered output: first load on the first rising edge after release.
      @(negedge clk);
      rst_n = 1'b1; d0 = 1'b1; oe = 1'b0;
      #1 check("reg_out_pre_edge", pad_b, 1'b0);
      @(posedge clk);
      #1 check("reg_out_post_edge", pad_b, 1'b1);
      check("reg_inv_post_edge", pad_g, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("rst_midcycle_b", pad_b, 1'b0);
      check("rst_midcycle_g", pad_g, 1'b1);
      @(negedge clk);
      rst_n = 1'b1; d0 = 1'b0; oe = 1'b0;

      // Registered OE: pad released until the edge that captures OE=1.
      @(posedge clk);
      @(negedge clk);
      oe = 1'b1;
      #1 check("oe_reg_hiz", pad_e, 1'b1);
      @(posedge clk);
      #1 check("oe_reg_drive", pad_e, 1'b0);

      // Clock enable low: D_OUT_0 change ignored for three edges.
      @(negedge clk);
      ce = 1'b0; d0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check($sformatf("ce_low_edge%0d", i), pad_b, 1'b0);
      end
      @(negedge clk);
      ce = 1'b1;
      @(posedge clk);
      #1 check("ce_high_take", pad_b, 1'b1);

      // DDR input: 1 at the rising edge, 0 at the falling edge.
      @(negedge clk);
      c_ext = 1'b1;
      @(posedge clk);
      #1 c_ext = 1'b0;
      @(negedge clk);
      #1 check("ddr_in0", c_in0, 1'b1);
      check("ddr_in1", c_in1, 1'b0);

      // Input latch.
      liv = 1'b0; d_ext = 1'b1;
      #1 check("latch_transparent", d_in0, 1'b1);
      liv = 1'b1;
      #1 d_ext = 1'b0;
      #1 check("latch_hold", d_in0, 1'b1);
      check("latch_din1", d_in1, 1'b0);
      liv = 1'b0;
      #1 check("latch_release", d_in0, 1'b0);

      // Randomized run against the edge-capture model.
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_q0 = 1'b0; m_q1 = 1'b0; m_bin0 = 1'b0; m_bin1 = 1'b0;
      m_cin0 = 1'b0; m_cin1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         ce    = ($urandom_range(0, 3) != 0);
         d0    = 1'($urandom_range(0, 1));
         d1    = 1'($urandom_range(0, 1));
         c_ext = 1'($urandom_range(0, 1));
         @(posedge clk);
         if (ce) begin
            m_bin0 = m_q0;      // pad b showed the old registered value
            m_q0   = d0;
            m_cin0 = c_ext;
         end
         #1;
         check("rnd_b_pad", pad_b, m_q0);
         check("rnd_f_pad_hi", pad_f, m_q0);
         check("rnd_g_pad", pad_g, !m_q0);
         check("rnd_g_in0", g_in0, !m_q0);
         check("rnd_b_in0", b_in0, m_bin0);
         check("rnd_c_in0", c_in0, m_cin0);
         check("rnd_c_in1_hold", c_in1, m_cin1);
         c_ext = 1'($urandom_range(0, 1));
         d1    = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (ce) begin
            m_q1   = d1;
            m_cin1 = c_ext;
            m_bin1 = m_q0;
         end
         #1;
         check("rnd_f_pad_lo", pad_f, m_q1);
         check("rnd_c_in1", c_in1, m_cin1);
         check("rnd_c_in0_hold", c_in0, m_cin0);
         check("rnd_b_in1", b_in1, m_bin1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
